// File: rtl/parking_pkg.sv
// Shared types and default constants for the car-park occupancy controller.
package parking_pkg;

  typedef enum logic [1:0] {
    G_CLOSED  = 2'd0,
    G_OPEN    = 2'd1,
    G_CLOSING = 2'd2
  } gate_state_t;

  localparam int DEF_CAPACITY     = 16;
  localparam int DEF_HOLD_CYCLES  = 32;
  localparam int DEF_CLOSE_CYCLES = 8;

  // Timer width able to hold the largest terminal value (max - 1) of either phase.
  function automatic int timer_width(input int hold_cycles, input int close_cycles);
    int m;
    m = (hold_cycles > close_cycles) ? hold_cycles : close_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/parking_gate_seq.sv
// One barrier gate sequencer: CLOSED -> OPEN (on req & allow) -> CLOSING -> CLOSED.
// The gate closes on the pass pulse or after HOLD_CYCLES open cycles, then needs
// CLOSE_CYCLES cycles before it can be granted again. gate and ack are registered.
module parking_gate_seq
  import parking_pkg::*;
#(
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic allow,
  input  logic pass,
  output logic gate,
  output logic ack
);

  localparam int TW = timer_width(HOLD_CYCLES, CLOSE_CYCLES);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);

  gate_state_t     state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            ack_nxt;

  // Next-state, timer and grant-pulse decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    timer_nxt = timer;
    ack_nxt   = 1'b0;
    case (state)
      G_CLOSED: begin
        if (req && allow) begin
          state_nxt = G_OPEN;
          timer_nxt = '0;
          ack_nxt   = 1'b1;
        end
      end
      G_OPEN: begin
        // A pass coinciding with the timeout is simply one close event.
        if (pass || (timer == HOLD_LAST)) begin
          state_nxt = G_CLOSING;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      G_CLOSING: begin
        if (timer == CLOSE_LAST) begin
          state_nxt = G_CLOSED;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        state_nxt = G_CLOSED;
        timer_nxt = '0;
      end
    endcase
  end

  // State, timer and registered gate/ack outputs; reset drops the gate at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= G_CLOSED;
      timer <= '0;
      gate  <= 1'b0;
      ack   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_nxt;
      timer <= timer_nxt;
      gate  <= (state_nxt == G_OPEN);
      ack   <= ack_nxt;
    end
  end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Car-park occupancy controller: saturating car count from the sensor pass
// pulses, full/empty flags, under/overflow error and two gate sequencers.
// Build option: define PARK_STICKY_ERR_EN to make err sticky until err_clr.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CNT_W        = $clog2(CAPACITY + 1),
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
  input  logic             decr,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic             entry_ack,
  output logic             exit_ack,
  output logic             err
);

  localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] count_nxt;
  logic             err_evt;

  // Saturating count update; an impossible step holds the count and flags an error.
  always_comb begin
    count_nxt = count;
    err_evt   = 1'b0;
    case ({incr, decr})
      2'b10: begin
        if (count == CAP_VAL) err_evt   = 1'b1;
        else                  count_nxt = count + CNT_W'(1);
      end
      2'b01: begin
        if (count == '0) err_evt   = 1'b1;
        else             count_nxt = count - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Registered count and flags, derived from the next count so they stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CAP_VAL);
      empty <= (count_nxt == '0);
    end
  end

`ifdef PARK_STICKY_ERR_EN
  // Sticky error: a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= err_evt | (err & ~err_clr);
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  // One-cycle error pulse registered with the offending event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= err_evt;
  end
`endif

  parking_gate_seq #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CLOSE_CYCLES(CLOSE_CYCLES)
  ) u_entry_gate (
    .clk  (clk),
    .rst  (rst),
    .req  (entry_req),
    .allow(~full),
    .pass (incr),
    .gate (entry_gate),
    .ack  (entry_ack)
  );

  parking_gate_seq #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CLOSE_CYCLES(CLOSE_CYCLES)
  ) u_exit_gate (
    .clk  (clk),
    .rst  (rst),
    .req  (exit_req),
    .allow(~empty),
    .pass (decr),
    .gate (exit_gate),
    .ack  (exit_ack)
  );

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Self-checking bench for parking_occupancy_ctrl: directed scenarios plus a
// randomized phase, every cycle compared against a countdown-style model.
module tb_parking_occupancy_ctrl;

  localparam int CAP   = 6;
  localparam int HOLD  = 8;
  localparam int CLOSE = 4;
  localparam int CW    = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          incr = 1'b0, decr = 1'b0;
  logic          entry_req = 1'b0, exit_req = 1'b0, err_clr = 1'b0;
  logic [CW-1:0] count;
  logic          full, empty, entry_gate, exit_gate, entry_ack, exit_ack, err;

  parking_occupancy_ctrl #(
    .CAPACITY    (CAP),
    .CNT_W       (CW),
    .HOLD_CYCLES (HOLD),
    .CLOSE_CYCLES(CLOSE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .incr      (incr),
    .decr      (decr),
    .entry_req (entry_req),
    .exit_req  (exit_req),
    .err_clr   (err_clr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .entry_gate(entry_gate),
    .exit_gate (exit_gate),
    .entry_ack (entry_ack),
    .exit_ack  (exit_ack),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a gate is described by how many open cycles and how many
  // closing cycles it still has left; the count is a plain integer.
  int m_count;
  bit m_err;
  int e_open, e_close, x_open, x_close;
  bit e_ack, x_ack;

  task automatic model_reset();
    m_count = 0; m_err = 0;
    e_open = 0; e_close = 0; x_open = 0; x_close = 0;
    e_ack = 0; x_ack = 0;
  endtask

  task automatic gate_model(input bit req, input bit allow, input bit pass,
                            inout int open_left, inout int close_left, output bit ack);
    ack = 0;
    if (open_left > 0) begin
      if (pass || open_left == 1) begin
        open_left  = 0;
        close_left = CLOSE;
      end else begin
        open_left--;
      end
    end else if (close_left > 0) begin
      close_left--;
    end else if (req && allow) begin
      open_left = HOLD;
      ack       = 1;
    end
  endtask

  task automatic model_edge();
    bit ev;
    bit was_full, was_empty;
    was_full  = (m_count == CAP);
    was_empty = (m_count == 0);
    gate_model(entry_req, !was_full, incr, e_open, e_close, e_ack);
    gate_model(exit_req, !was_empty, decr, x_open, x_close, x_ack);
    ev = 0;
    if (incr && !decr) begin
      if (m_count == CAP) ev = 1; else m_count++;
    end else if (decr && !incr) begin
      if (m_count == 0) ev = 1; else m_count--;
    end
`ifdef PARK_STICKY_ERR_EN
    m_err = ev || (m_err && !err_clr);
`else
    m_err = ev;
`endif
  endtask

  task automatic compare_all();
    check("count",      count,      m_count);
    check("full",       full,       m_count == CAP);
    check("empty",      empty,      m_count == 0);
    check("entry_gate", entry_gate, e_open > 0);
    check("exit_gate",  exit_gate,  x_open > 0);
    check("entry_ack",  entry_ack,  e_ack);
    check("exit_ack",   exit_ack,   x_ack);
    check("err",        err,        m_err);
  endtask

  // One clock: model advances at the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse(input bit i, input bit d);
    incr = i; decr = d;
    step();
    incr = 0; decr = 0;
  endtask

  task automatic wait_entry_ack(input string tag);
    int n = 0;
    while (!e_ack && n < 40) begin
      step();
      n++;
    end
    check(tag, entry_ack, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_hi, n_lo;
    logic seen_gate;

    // Reset and idle.
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);
    check("rst_gates", {entry_gate, exit_gate, entry_ack, exit_ack}, 0);
    check("rst_err",   err,   0);
    rst = 1;
    repeat (3) step();

    // Fill to capacity, one car per grant.
    entry_req = 1;
    for (int k = 1; k <= CAP; k++) begin
      wait_entry_ack($sformatf("fill_ack%0d", k));
      pulse(1, 0);
      check($sformatf("fill_count%0d", k), count, k);
    end
    check("fill_full", full, 1);
    seen_gate = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen_gate = seen_gate | entry_gate | entry_ack;
    end
    check("full_refuses_entry", seen_gate, 0);
    entry_req = 0;

    // Down to 2, then simultaneous incr/decr.
    repeat (CAP - 2) pulse(0, 1);
    check("down_to_two", count, 2);
    pulse(1, 1);
    check("both_count", count, 2);
    check("both_err",   err,   0);

    // Underflow.
    repeat (2) pulse(0, 1);
    pulse(0, 1);
    check("under_count", count, 0);
    check("under_err",   err,   1);
    step();
`ifdef PARK_STICKY_ERR_EN
    check("sticky_hold", err, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    check("sticky_clr", err, 0);
`else
    check("pulse_err_gone", err, 0);
`endif

    // Timeout: no car passes.
    repeat (HOLD + CLOSE + 2) step();
    entry_req = 1;
    wait_entry_ack("to_ack");
    n_hi = 0;
    while (entry_gate && n_hi < 100) begin
      n_hi++;
      step();
    end
    check("hold_len", n_hi, HOLD);
    n_lo = 0;
    while (!entry_ack && n_lo < 100) begin
      if (!entry_gate) n_lo++;
      step();
    end
    // CLOSE_CYCLES closing cycles, then one closed cycle where the held request is granted.
    check("close_gap", n_lo, CLOSE + 1);
    entry_req = 0;

    // Async reset with the gate open and five cars inside.
    repeat (5) pulse(1, 0);
    repeat (HOLD + CLOSE + 2) step();
    entry_req = 1;
    wait_entry_ack("pre_rst_ack");
    check("pre_rst_count", count, 5);
    #2 rst = 0;
    #1;
    check("async_gate",  entry_gate, 0);
    check("async_count", count, 0);
    check("async_empty", empty, 1);
    model_reset();
    @(negedge clk);
    rst = 1;
    wait_entry_ack("post_rst_ack");
    entry_req = 0;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) entry_req = ~entry_req;
      if ($urandom_range(0, 7) == 0) exit_req  = ~exit_req;
      incr    = ($urandom_range(0, 5) == 0);
      decr    = ($urandom_range(0, 5) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    incr = 0; decr = 0; err_clr = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
